count_tracker: RTL and testbench

- Passive checker for the loadable up-counter used in the design's posedge counter path.
- Samples the counter's control inputs (cen, wen, dat) and its registered output every clock.
- Predicts the next counter value independently and compares it against the observed value.
- Reports mismatches as a pulse, a saturating error count and a captured first-failure record.
- Sits beside the counter as its reader/checker counterpart; drives nothing into the counter.

---
 rtl/count_tracker.sv | 136 +++++++++++++
 tb/tb_count_tracker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_tracker.sv
// count_tracker: passive next-value checker for a loadable up-counter.
// Predicts each counter value from the previous cycle's controls and flags mismatches.
module count_tracker #(
    parameter int WIDTH     = 8,
    parameter int ECW       = 8,
    parameter int ERR_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             obs_cen,
    input  logic             obs_wen,
    input  logic [WIDTH-1:0] obs_dat,
    input  logic [WIDTH-1:0] obs_cnt,
    output logic             err,
    output logic [ECW-1:0]   err_cnt,
    output logic             first_vld,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ECW-1:0] CNT_MAX = '1;
    localparam logic [ECW-1:0] LIMIT   = ECW'(ERR_LIMIT);

    state_t           state, state_nx;
    logic             h_cen, h_cen_nx;
    logic             h_wen, h_wen_nx;
    logic [WIDTH-1:0] h_dat, h_dat_nx;
    logic [WIDTH-1:0] h_cnt, h_cnt_nx;
    logic             err_nx;
    logic [ECW-1:0]   cnt_nx, cnt_inc;
    logic             fv_nx;
    logic [WIDTH-1:0] fe_nx, fo_nx;
    logic [WIDTH-1:0] exp_v;
    logic             miss;

    // load wins over enable, just like the counter itself
    assign exp_v   = h_wen ? h_dat : h_cnt + {{(WIDTH-1){1'b0}}, h_cen};
    assign miss    = (exp_v != obs_cnt);
    assign cnt_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
    assign halted  = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_cen     <= 1'b0;
            h_wen     <= 1'b0;
            h_dat     <= '0;
            h_cnt     <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            first_vld <= 1'b0;
            first_exp <= '0;
            first_obs <= '0;
        end else begin
            state     <= state_nx;
            h_cen     <= h_cen_nx;
            h_wen     <= h_wen_nx;
            h_dat     <= h_dat_nx;
            h_cnt     <= h_cnt_nx;
            err       <= err_nx;
            err_cnt   <= cnt_nx;
            first_vld <= fv_nx;
            first_exp <= fe_nx;
            first_obs <= fo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        h_cen_nx = h_cen;
        h_wen_nx = h_wen;
        h_dat_nx = h_dat;
        h_cnt_nx = h_cnt;
        err_nx   = 1'b0;
        cnt_nx   = err_cnt;
        fv_nx    = first_vld;
        fe_nx    = first_exp;
        fo_nx    = first_obs;
        if (clr) begin
            cnt_nx   = '0;
            fv_nx    = 1'b0;
            fe_nx    = '0;
            fo_nx    = '0;
            state_nx = en ? PRIME : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) state_nx = PRIME;
                end
                PRIME, CHECK: begin
                    if (!en) begin
                        // drop history so a gap can never produce a false compare
                        state_nx = IDLE;
                        h_cen_nx = 1'b0;
                        h_wen_nx = 1'b0;
                        h_dat_nx = '0;
                        h_cnt_nx = '0;
                    end else begin
                        state_nx = CHECK;
                        h_cen_nx = obs_cen;
                        h_wen_nx = obs_wen;
                        h_dat_nx = obs_dat;
                        h_cnt_nx = obs_cnt;
                        if (state == CHECK && miss) begin
                            err_nx = 1'b1;
                            cnt_nx = cnt_inc;
                            if (!first_vld) begin
                                fv_nx = 1'b1;
                                fe_nx = exp_v;
                                fo_nx = obs_cnt;
                            end
                            if (cnt_inc == LIMIT) state_nx = HALT;
                        end
                    end
                end
                HALT: begin
                    state_nx = HALT;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_tracker.sv
// tb_count_tracker: vector table, directed corner sequences and random
// stimulus checked against a run-length/last-sample reference model.
module tb_count_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       en = 1'b0, clr = 1'b0, obs_cen = 1'b0, obs_wen = 1'b0;
    logic [7:0] obs_dat = '0, obs_cnt = '0;

    logic       err0, err1, fv0, fv1, h0, h1;
    logic [7:0] ec0, ec1, fe0, fe1, fo0, fo1;

    count_tracker #(.WIDTH(8), .ECW(8), .ERR_LIMIT(255)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .obs_cen(obs_cen), .obs_wen(obs_wen), .obs_dat(obs_dat), .obs_cnt(obs_cnt),
        .err(err0), .err_cnt(ec0), .first_vld(fv0), .first_exp(fe0),
        .first_obs(fo0), .halted(h0)
    );

    count_tracker #(.WIDTH(8), .ECW(8), .ERR_LIMIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .obs_cen(obs_cen), .obs_wen(obs_wen), .obs_dat(obs_dat), .obs_cnt(obs_cnt),
        .err(err1), .err_cnt(ec1), .first_vld(fv1), .first_exp(fe1),
        .first_obs(fo1), .halted(h1)
    );

    int checks = 0;
    int failures = 0;

    // reference model, one slot per instance
    int         lim [2] = '{255, 2};
    int         m_run [2];
    bit         m_halt [2];
    bit         m_err [2];
    int         m_cnt [2];
    bit         m_fv [2];
    logic [7:0] m_fe [2];
    logic [7:0] m_fo [2];
    logic       p_ce [2];
    logic       p_we [2];
    logic [7:0] p_d [2];
    logic [7:0] p_q [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_halt[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
            m_fv[i] = 0; m_fe[i] = '0; m_fo[i] = '0;
            p_ce[i] = 0; p_we[i] = 0; p_d[i] = '0; p_q[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input logic e, input logic c,
                              input logic ce, input logic we,
                              input logic [7:0] d, input logic [7:0] q);
        logic [7:0] ex;
        m_err[i] = 0;
        if (c) begin
            m_cnt[i] = 0; m_fv[i] = 0; m_fe[i] = '0; m_fo[i] = '0;
            m_halt[i] = 0;
            m_run[i] = e ? 1 : 0;
        end else if (!m_halt[i]) begin
            if (!e) begin
                m_run[i] = 0;
            end else begin
                if (m_run[i] >= 2) begin
                    ex = p_we[i] ? p_d[i] : p_q[i] + {7'b0, p_ce[i]};
                    if (ex !== q) begin
                        m_err[i] = 1;
                        if (m_cnt[i] < 255) m_cnt[i]++;
                        if (!m_fv[i]) begin
                            m_fv[i] = 1; m_fe[i] = ex; m_fo[i] = q;
                        end
                        if (m_cnt[i] == lim[i]) m_halt[i] = 1;
                    end
                end
                p_ce[i] = ce; p_we[i] = we; p_d[i] = d; p_q[i] = q;
                m_run[i] = (m_run[i] < 2) ? m_run[i] + 1 : 2;
            end
        end
    endtask

    task automatic cmp_model();
        check("dut_vs_model",
              {5'b0, err0, ec0, fv0, fe0, fo0, h0},
              {5'b0, m_err[0], 8'(m_cnt[0]), m_fv[0], m_fe[0], m_fo[0], m_halt[0]});
        check("dut2_vs_model",
              {5'b0, err1, ec1, fv1, fe1, fo1, h1},
              {5'b0, m_err[1], 8'(m_cnt[1]), m_fv[1], m_fe[1], m_fo[1], m_halt[1]});
    endtask

    task automatic cycle(input logic e, input logic c, input logic ce, input logic we,
                         input logic [7:0] d, input logic [7:0] q);
        en = e; clr = c; obs_cen = ce; obs_wen = we; obs_dat = d; obs_cnt = q;
        model_step(0, e, c, ce, we, d, q);
        model_step(1, e, c, ce, we, d, q);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        en = 0; clr = 0; obs_cen = 0; obs_wen = 0; obs_dat = '0; obs_cnt = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_model();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en, clr, cen, wen;
        logic [7:0] dat, cnt;
        logic       err;
        logic [7:0] ec;
        logic       fv;
        logic [7:0] fe, fo;
    } vec_t;

    vec_t tv [12];
    logic [7:0] ctr;
    logic [7:0] flt;
    logic       re, rc, rce, rwe;
    logic [7:0] rd;

    initial begin
        //          en clr cen wen dat    cnt    err ec    fv fe     fo
        tv[0]  = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[1]  = '{1, 0, 1, 1, 8'h5A, 8'h01, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[2]  = '{1, 0, 1, 0, 8'h00, 8'h5A, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[3]  = '{1, 0, 1, 0, 8'h00, 8'h5B, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[4]  = '{1, 0, 1, 1, 8'h5A, 8'h5C, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[5]  = '{1, 0, 1, 0, 8'h00, 8'h5B, 1, 8'd1, 1, 8'h5A, 8'h5B};
        tv[6]  = '{1, 0, 1, 0, 8'h00, 8'h5C, 0, 8'd1, 1, 8'h5A, 8'h5B};
        tv[7]  = '{1, 1, 1, 1, 8'hFE, 8'h5D, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[8]  = '{1, 0, 1, 0, 8'h00, 8'hFE, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[9]  = '{1, 0, 1, 0, 8'h00, 8'hFF, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[10] = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 8'd0, 0, 8'h00, 8'h00};
        tv[11] = '{1, 0, 1, 0, 8'h00, 8'h01, 0, 8'd0, 0, 8'h00, 8'h00};

        // reset state, then a clean count 0..20
        do_reset();
        check("reset_outputs", {5'b0, err0, ec0, fv0, fe0, fo0, h0}, 32'd0);
        for (int k = 0; k <= 20; k++) cycle(1, 0, 1, 0, 8'h00, 8'(k));
        check("clean_run_errcnt", {24'b0, ec0}, 32'd0);
        check("clean_run_fv", {31'b0, fv0}, 32'd0);

        // load-vs-enable, wrap at FF->00, clr
        do_reset();
        for (int r = 0; r < 12; r++) begin
            cycle(tv[r].en, tv[r].clr, tv[r].cen, tv[r].wen, tv[r].dat, tv[r].cnt);
            check($sformatf("tbl_row%0d", r),
                  {5'b0, err0, ec0, fv0, fe0, fo0},
                  {5'b0, tv[r].err, tv[r].ec, tv[r].fv, tv[r].fe, tv[r].fo});
        end

        // three corruptions: expected 10/20/30, observed 11/22/33
        do_reset();
        cycle(1, 0, 0, 0, 8'h00, 8'h00);
        cycle(1, 0, 0, 1, 8'h10, 8'h00);
        cycle(1, 0, 0, 1, 8'h20, 8'h11);
        cycle(1, 0, 0, 1, 8'h30, 8'h22);
        cycle(1, 0, 0, 0, 8'h00, 8'h33);
        cycle(1, 0, 0, 0, 8'h00, 8'h33);
        check("corrupt_errcnt", {24'b0, ec0}, 32'd3);
        check("corrupt_first_exp", {24'b0, fe0}, 32'h10);
        check("corrupt_first_obs", {24'b0, fo0}, 32'h11);
        check("limit_halted", {31'b0, h1}, 32'd1);

        // counter keeps running corrupted; limited instance stays halted
        for (int k = 0; k < 4; k++) cycle(1, 0, 1, 0, 8'h00, 8'(8'hB4 + k));
        check("limit_errcnt_held", {24'b0, ec1}, 32'd2);
        check("limit_still_halted", {31'b0, h1}, 32'd1);
        cycle(1, 1, 1, 0, 8'h00, 8'h3F);
        check("clr_halted", {31'b0, h1}, 32'd0);
        check("clr_errcnt", {24'b0, ec1}, 32'd0);
        cycle(1, 0, 1, 0, 8'h00, 8'h40);
        cycle(1, 0, 1, 0, 8'h00, 8'h41);
        check("after_clr_no_err", {30'b0, err0, err1}, 32'd0);

        // en gap while the counter loads 80
        cycle(0, 0, 0, 1, 8'h80, 8'h42);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 8'h00, 8'(8'h80 + k));
        cycle(1, 0, 1, 0, 8'h00, 8'h84);
        cycle(1, 0, 1, 0, 8'h00, 8'h85);
        cycle(1, 0, 1, 0, 8'h00, 8'h86);
        check("gap_no_err", {30'b0, err0, err1}, 32'd0);
        check("gap_errcnt", {24'b0, ec0}, 32'd0);

        // fault then asynchronous reset mid-CHECK
        cycle(1, 0, 1, 0, 8'h00, 8'h99);
        check("fault_errcnt", {24'b0, ec0}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_dut", {5'b0, err0, ec0, fv0, fe0, fo0, h0}, 32'd0);
        check("async_rst_dut2", {5'b0, err1, ec1, fv1, fe1, fo1, h1}, 32'd0);
        #2;
        rst_n = 1'b1;

        // random traffic against the model
        do_reset();
        ctr = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            re  = ($urandom % 20) != 0;
            rc  = ($urandom % 60) == 0;
            rce = 1'($urandom);
            rwe = ($urandom % 8) == 0;
            rd  = 8'($urandom);
            flt = (($urandom % 16) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            cycle(re, rc, rce, rwe, rd, ctr ^ flt);
            ctr = rwe ? rd : ctr + {7'b0, rce};
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
